// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - shared state encoding and width helpers for the run-length encoder
package rle_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // Token layout on the holding register: {symbol, run_length, last}
    function automatic int tok_w(input int data_w, input int cnt_w);
        return data_w + cnt_w;
    endfunction

    function automatic int max_run(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/rle_token_reg.sv
// rtl/rle_token_reg.sv - single-entry output holding register with load port and valid/ready drain
module rle_token_reg #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // A load in the same cycle as a drain wins, so valid stays high.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= load_data_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/rle_encoder_p.sv
// rtl/rle_encoder_p.sv - streaming run-length encoder with max-run split and last flush; RLE_STATS_EN adds counters
module rle_encoder_p
    import rle_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_cnt,
`ifdef RLE_STATS_EN
    output logic [31:0]       stat_syms,
    output logic [31:0]       stat_toks,
`endif
    output logic              out_last
);

    localparam int              TOK_W   = tok_w(DATA_W, CNT_W);
    localparam logic [CNT_W-1:0] MAX_RUN = CNT_W'(max_run(CNT_W));

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   run_data_q, run_data_d;
    logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;

    logic                slot_free;
    logic                in_xfer;
    logic                extend;
    logic                tok_load;
    logic [DATA_W-1:0]   tok_data;
    logic [CNT_W-1:0]    tok_cnt;
    logic                tok_last;
    logic [TOK_W:0]      tok_q;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = !rst && (state_q != FLUSH) && slot_free;
    assign in_xfer   = in_valid && in_ready;
    assign extend    = (in_data == run_data_q) && (run_cnt_q < MAX_RUN);

    always_comb begin
        state_d    = state_q;
        run_data_d = run_data_q;
        run_cnt_d  = run_cnt_q;
        tok_load   = 1'b0;
        tok_data   = '0;
        tok_cnt    = '0;
        tok_last   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    run_data_d = in_data;
                    run_cnt_d  = CNT_W'(1);
                    if (in_last) begin
                        tok_load = 1'b1;
                        tok_data = in_data;
                        tok_cnt  = CNT_W'(1);
                        tok_last = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (in_xfer) begin
                    if (extend && in_last) begin
                        tok_load = 1'b1;
                        tok_data = run_data_q;
                        tok_cnt  = run_cnt_q + CNT_W'(1);
                        tok_last = 1'b1;
                        state_d  = IDLE;
                    end else if (extend) begin
                        run_cnt_d = run_cnt_q + CNT_W'(1);
                    end else begin
                        // Symbol change and max-run split share this one token.
                        tok_load   = 1'b1;
                        tok_data   = run_data_q;
                        tok_cnt    = run_cnt_q;
                        run_data_d = in_data;
                        run_cnt_d  = CNT_W'(1);
                        if (in_last) begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    tok_load = 1'b1;
                    tok_data = run_data_q;
                    tok_cnt  = run_cnt_q;
                    tok_last = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            run_data_q <= '0;
            run_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            run_data_q <= run_data_d;
            run_cnt_q  <= run_cnt_d;
        end
    end

    rle_token_reg #(
        .W(TOK_W + 1)
    ) u_tok (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tok_load),
        .load_data_i({tok_data, tok_cnt, tok_last}),
        .ready_i    (out_ready),
        .valid_o    (out_valid),
        .data_o     (tok_q)
    );

    assign out_data = tok_q[TOK_W:CNT_W+1];
    assign out_cnt  = tok_q[CNT_W:1];
    assign out_last = tok_q[0];

`ifdef RLE_STATS_EN
    logic [31:0] stat_syms_q;
    logic [31:0] stat_toks_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_syms_q <= '0;
            stat_toks_q <= '0;
        end else begin
            if (in_xfer) begin
                stat_syms_q <= stat_syms_q + 32'd1;
            end
            if (out_valid && out_ready) begin
                stat_toks_q <= stat_toks_q + 32'd1;
            end
        end
    end

    assign stat_syms = stat_syms_q;
    assign stat_toks = stat_toks_q;
`endif

endmodule

// File: tb/tb_rle_encoder_p.sv
// tb/tb_rle_encoder_p.sv - self-checking bench for rle_encoder_p (RLE_STATS_EN enables the counter checks)
module tb_rle_encoder_p;

    typedef logic [16:0] tok_t;   // {symbol[7:0], count[7:0], last}

    logic clk;
    logic rst;

    logic       iv8, ir8, il8, ov8, ordy8, ol8;
    logic [7:0] id8, od8, oc8;
    logic       iv2, ir2, il2, ov2, ordy2, ol2;
    logic [7:0] id2, od2;
    logic [1:0] oc2;
`ifdef RLE_STATS_EN
    logic [31:0] ss8, st8, ss2, st2;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    tok_t exp8[$];
    tok_t exp2[$];
    logic [7:0] stim[$];
    logic mon_stall = 1'b0;
    int   stall_cnt = 0;

    rle_encoder_p #(.DATA_W(8), .CNT_W(8)) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (iv8),
        .in_ready (ir8),
        .in_data  (id8),
        .in_last  (il8),
        .out_valid(ov8),
        .out_ready(ordy8),
        .out_data (od8),
        .out_cnt  (oc8),
`ifdef RLE_STATS_EN
        .stat_syms(ss8),
        .stat_toks(st8),
`endif
        .out_last (ol8)
    );

    rle_encoder_p #(.DATA_W(8), .CNT_W(2)) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (iv2),
        .in_ready (ir2),
        .in_data  (id2),
        .in_last  (il2),
        .out_valid(ov2),
        .out_ready(ordy2),
        .out_data (od2),
        .out_cnt  (oc2),
`ifdef RLE_STATS_EN
        .stat_syms(ss2),
        .stat_toks(st2),
`endif
        .out_last (ol2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: group the stream into maximal equal-symbol runs, cut each run into
    // chunks of at most maxr, and flag the final chunk of the stream as last.
    task automatic model(input int sel);
        tok_t loc[$];
        tok_t tl;
        int   i, j, n, c, maxr;
        maxr = (sel != 0) ? 3 : 255;
        i = 0;
        while (i < stim.size()) begin
            j = i;
            while (j < stim.size() && stim[j] == stim[i]) j++;
            n = j - i;
            while (n > 0) begin
                c = (n > maxr) ? maxr : n;
                loc.push_back({stim[i], 8'(c), 1'b0});
                n -= c;
            end
            i = j;
        end
        if (loc.size() > 0) begin
            tl = loc.pop_back();
            tl[0] = 1'b1;
            loc.push_back(tl);
        end
        foreach (loc[k]) begin
            if (sel != 0) exp2.push_back(loc[k]);
            else          exp8.push_back(loc[k]);
        end
    endtask

    always @(negedge clk) begin : cmp
        tok_t t;
        if (!rst && ov8 && ordy8) begin
            if (exp8.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL tok8_unexpected: got {%0h,%0d,%0b} expected no token", od8, oc8, ol8);
            end else begin
                t = exp8.pop_front();
                chk("tok8_data", 32'(od8), 32'(t[16:9]));
                chk("tok8_cnt",  32'(oc8), 32'(t[8:1]));
                chk("tok8_last", 32'(ol8), 32'(t[0]));
            end
        end
        if (!rst && ov2 && ordy2) begin
            if (exp2.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL tok2_unexpected: got {%0h,%0d,%0b} expected no token", od2, oc2, ol2);
            end else begin
                t = exp2.pop_front();
                chk("tok2_data", 32'(od2), 32'(t[16:9]));
                chk("tok2_cnt",  32'(oc2), 32'(t[8:1]));
                chk("tok2_last", 32'(ol2), 32'(t[0]));
            end
        end
        if (mon_stall && !ir8) stall_cnt++;
    end

    task automatic send_sym(input int sel, input logic [7:0] d, input logic last);
        logic acc;
        acc = 1'b0;
        if (sel != 0) begin iv2 = 1'b1; id2 = d; il2 = last; end
        else          begin iv8 = 1'b1; id8 = d; il8 = last; end
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = (sel != 0) ? ir2 : ir8;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
        if (sel != 0) begin iv2 = 1'b0; il2 = 1'b0; end
        else          begin iv8 = 1'b0; il8 = 1'b0; end
    endtask

    task automatic send_stream(input int sel, input logic with_last);
        for (int i = 0; i < stim.size(); i++)
            send_sym(sel, stim[i], with_last && (i == stim.size() - 1));
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (exp8.size() != 0 || exp2.size() != 0); k++)
            @(posedge clk);
        #1;
        chk("drain8_left", 32'(exp8.size()), 32'd0);
        chk("drain2_left", 32'(exp2.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        iv8 = 1'b0; id8 = '0; il8 = 1'b0; ordy8 = 1'b1;
        iv2 = 1'b0; id2 = '0; il2 = 1'b0; ordy2 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_in_ready",  32'(ir8), 32'd0);
        chk("rst_out_valid", 32'(ov8), 32'd0);
        chk("rst_out_data",  32'(od8), 32'd0);
        chk("rst_out_cnt",   32'(oc8), 32'd0);
        chk("rst_out_last",  32'(ol8), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // A A A B C(last)
        stim = '{8'h41, 8'h41, 8'h41, 8'h42, 8'h43};
        model(0);
        chk("pin1_n",    32'(exp8.size()), 32'd3);
        chk("pin1_tok0", 32'(exp8[0]), 32'({8'h41, 8'd3, 1'b0}));
        chk("pin1_tok1", 32'(exp8[1]), 32'({8'h42, 8'd1, 1'b0}));
        chk("pin1_tok2", 32'(exp8[2]), 32'({8'h43, 8'd1, 1'b1}));
        stall_cnt = 0; mon_stall = 1'b1;
        send_stream(0, 1'b1);
        repeat (3) @(posedge clk);
        #1; mon_stall = 1'b0;
        chk("t1_stall_cycles", 32'(stall_cnt), 32'd1);
        drain();

        // Seven 0x55 on the MAX_RUN=3 instance
        stim = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55};
        model(1);
        chk("pin2_n",    32'(exp2.size()), 32'd3);
        chk("pin2_tok0", 32'(exp2[0]), 32'({8'h55, 8'd3, 1'b0}));
        chk("pin2_tok2", 32'(exp2[2]), 32'({8'h55, 8'd1, 1'b1}));
        send_stream(1, 1'b1);
        drain();

        // 5 5 7(last): FLUSH stalls in_ready exactly one cycle
        stim = '{8'h05, 8'h05, 8'h07};
        model(0);
        chk("pin3_tok0", 32'(exp8[0]), 32'({8'h05, 8'd2, 1'b0}));
        stall_cnt = 0; mon_stall = 1'b1;
        send_stream(0, 1'b1);
        repeat (3) @(posedge clk);
        #1; mon_stall = 1'b0;
        chk("t3_stall_cycles", 32'(stall_cnt), 32'd1);
        drain();

        // Backpressure with a pending {11,2,0}
        stim = '{8'h11, 8'h11, 8'h22, 8'h33};
        model(0);
        send_sym(0, 8'h11, 1'b0);
        send_sym(0, 8'h11, 1'b0);
        ordy8 = 1'b0;
        send_sym(0, 8'h22, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(ov8), 32'd1);
            chk("bp_in_ready",  32'(ir8), 32'd0);
            chk("bp_out_data",  32'(od8), 32'h11);
            chk("bp_out_cnt",   32'(oc8), 32'd2);
            @(posedge clk); #1;
        end
        ordy8 = 1'b1;
        send_sym(0, 8'h33, 1'b1);
        drain();

        // Reset discards an open run
        stim = '{8'h09, 8'h09, 8'h09};
        send_stream(0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_in_ready", 32'(ir8), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_out_valid", 32'(ov8), 32'd0);
        chk("rst2_out_data",  32'(od8), 32'd0);
        chk("rst2_out_cnt",   32'(oc8), 32'd0);
        chk("rst2_out_last",  32'(ol8), 32'd0);
        @(posedge clk); #1;
        stim = '{8'h04};
        model(0);
        chk("pin5_tok0", 32'(exp8[0]), 32'({8'h04, 8'd1, 1'b1}));
        send_stream(0, 1'b1);
        drain();

`ifdef RLE_STATS_EN
        begin
            int ntok;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            stim.delete();
            for (int k = 0; k < 100; k++) stim.push_back(8'($urandom_range(0, 3)));
            model(0);
            ntok = exp8.size();
            send_stream(0, 1'b1);
            drain();
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk("stat_syms", ss8, 32'd100);
            chk("stat_toks", st8, 32'(ntok));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rle_encoder_p.md
# rle_encoder_p

Parametrised streaming run-length encoder that compresses a symbol stream into `{symbol, run_length}` tokens. It extends the first-generation encoder with configurable symbol and count widths, valid/ready handshakes on both sides, max-run splitting and an explicit end-of-stream (`last`) flush. It sits between the pixel/byte source and the packer or FIFO feeding the output link.

## Interface
- `DATA_W`, default 8: symbol width in bits.
- `CNT_W`, default 8: run-length field width in bits; the maximum run is `MAX_RUN = 2**CNT_W-1`.
- `clk`, input, 1: clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: the input symbol is valid.
- `in_ready`, output, 1: the encoder accepts the symbol this cycle.
- `in_data`, input, `DATA_W`: input symbol.
- `in_last`, input, 1: the symbol is the final one of the stream.
- `out_valid`, output, 1: a token is valid.
- `out_ready`, input, 1: the downstream block accepts the token.
- `out_data`, output, `DATA_W`: the run's symbol.
- `out_cnt`, output, `CNT_W`: run length, 1..`MAX_RUN`; 0 is never emitted.
- `out_last`, output, 1: the token closes the stream.

## Operation
- Input transfer: `in_valid && in_ready`. Output transfer: `out_valid && out_ready`.
- `in_ready = !rst && state!=FLUSH && (!out_valid || out_ready)`. This is combinational; no input is accepted unless the output slot is free or draining this cycle.
- **IDLE** (no open run): an accepted symbol sets `run_data=in_data`, `run_cnt=1`.
  - If `in_last=0`, go to RUN.
  - If `in_last=1`, emit `{in_data,1,last=1}` and stay in IDLE.
- **RUN**: for an accepted symbol with `in_last=0`:
  - If `in_data==run_data` and `run_cnt<MAX_RUN`: `run_cnt++` and nothing is emitted.
  - Otherwise (mismatch, or `run_cnt==MAX_RUN`): emit `{run_data,run_cnt,0}`, then `run_data=in_data`, `run_cnt=1`.
- RUN, accepted symbol with `in_last=1`:
  - If it matches and `run_cnt<MAX_RUN`: emit `{run_data,run_cnt+1,1}` and go to IDLE.
  - Otherwise: emit `{run_data,run_cnt,0}`, load `run_data=in_data`, `run_cnt=1`, and go to FLUSH.
- **FLUSH**: `in_ready=0`. When the output slot is free (`!out_valid || out_ready`), emit `{run_data,1,1}` and go to IDLE.
- The output register holds its value while `out_valid && !out_ready`. It clears `out_valid` on transfer unless a new token is loaded in the same cycle.
- With no `in_last`, an open run is held indefinitely. There is no timeout.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_cnt=0`, `out_last=0`, state IDLE, `run_cnt=0`, `run_data=0`. `in_ready=0` while `rst=1`.
- Latency: a token is valid on the cycle after the input transfer that closes the run.
- Throughput: one symbol per cycle while `out_ready=1`. The FLUSH case costs one extra input-stall cycle.
- Simultaneous output transfer and new token load: the new token wins and `out_valid` stays 1.
- `rst` mid-run or mid-FLUSH discards the open run and any pending token. No partial token is emitted.
- The max-run split and a symbol change in the same cycle produce exactly one token.

## Configuration
- `RLE_STATS_EN` defined: adds outputs `stat_syms` (32-bit count of accepted symbols) and `stat_toks` (32-bit count of transferred tokens).
  - Both clear on `rst` and wrap modulo 2^32.
  - `stat_syms` updates on the cycle after the input transfer; `stat_toks` updates on the cycle after the output transfer.
- `RLE_STATS_EN` undefined: the ports and counters are absent, and the behaviour is otherwise identical.

## Structure
- Package `rle_pkg`:
  - state enum `{IDLE, RUN, FLUSH}`;
  - a token struct/width helper `TOK_W = DATA_W+CNT_W`;
  - the `MAX_RUN` computation.
- One sub-module, `rle_token_reg`: a single-entry output holding register with valid/ready and a load port, parametrised on `TOK_W+1`.

## Test plan
- `DATA_W=8`, `CNT_W=8`, `out_ready=1`; input `A A A B` then `C` with `last` -> tokens `{A,3,0}`, `{B,1,0}`, `{C,1,1}`, the last taking one FLUSH stall cycle.
- `CNT_W=2` (`MAX_RUN=3`); input seven `0x55` with `last` on the seventh -> `{55,3,0}`, `{55,3,0}`, `{55,1,1}`.
- Input `5,5,7` with `last` on `7`, `out_ready=1` -> `{5,2,0}`, then FLUSH `{7,1,1}`; `in_ready` is low exactly one cycle.
- Backpressure: hold `out_ready=0` for 5 cycles with a token pending -> `in_ready=0`, and `out_data`/`out_cnt` are stable and unchanged; on release, no symbol is lost or duplicated.
- `rst` asserted for one cycle after `9,9,9` with no last -> no token emitted, all outputs 0; the next stream `4` with `last` -> `{4,1,1}`.
- With `RLE_STATS_EN`, 100 random symbols ending in `last` -> `stat_syms=100` and `stat_toks` equals the tokens transferred.
